// File: rtl/red_pkg.sv
// Shared definitions for the reduced RV32I fetch/decode front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds opcode/funct encodings, ALU control codes, the fetch FSM state
// enum and the control bundle that red_decode produces for the datapath.
package red_pkg;

  localparam int XLEN = 32;
  localparam int RLEN = 5;
  localparam int ALEN = 3;

  // Major opcodes (ir[6:0])
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  // funct3 / funct7 encodings
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  // ALU control codes
  localparam logic [ALEN-1:0] ALU_ADD = 3'b000;
  localparam logic [ALEN-1:0] ALU_SUB = 3'b001;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Control bundle: everything the datapath needs for one instruction,
  // plus branch qualifiers consumed by the fetch controller.
  typedef struct packed {
    logic [XLEN-1:0] imm_op;
    logic            reg_write;
    logic [ALEN-1:0] alu_ctrl;
    logic            alu_src;
    logic [RLEN-1:0] rs1;
    logic [RLEN-1:0] rs2;
    logic [RLEN-1:0] rd;
    logic            mem_write;
    logic            result_src;
    logic            is_branch;
    logic            branch_ne;
  } ctrl_t;

endpackage

// File: rtl/red_decode.sv
// Decodes one RV32I subset instruction word into the datapath control bundle.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows i_ir continuously.
//
// Ports:
//   i_ir      - instruction word
//   o_ctrl    - control bundle (immediate, enables, ALU op, register fields)
//   o_illegal - 1 when the opcode/funct combination is not supported
module red_decode
  import red_pkg::*;
(
  input  logic [XLEN-1:0] i_ir,
  output ctrl_t           o_ctrl,
  output logic            o_illegal
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;

  assign w_opcode = i_ir[6:0];
  assign w_f3     = i_ir[14:12];
  assign w_f7     = i_ir[31:25];

  assign w_imm_i = {{20{i_ir[31]}}, i_ir[31:20]};
  assign w_imm_s = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
  assign w_imm_b = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};

  always_comb begin
    o_ctrl     = '0;
    o_illegal  = 1'b1;
    // Register fields are passed through for every instruction, used or not.
    o_ctrl.rs1 = i_ir[19:15];
    o_ctrl.rs2 = i_ir[24:20];
    o_ctrl.rd  = i_ir[11:7];

    case (w_opcode)
      OP_IMM: begin
        if (w_f3 == F3_ADD) begin
          o_illegal        = 1'b0;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.alu_ctrl  = ALU_ADD;
          o_ctrl.imm_op    = w_imm_i;
        end
      end
      OP: begin
        if (w_f3 == F3_ADD && (w_f7 == F7_ADD || w_f7 == F7_SUB)) begin
          o_illegal        = 1'b0;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.alu_ctrl  = (w_f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
        end
      end
      LOAD: begin
        if (w_f3 == F3_W) begin
          o_illegal         = 1'b0;
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.alu_src    = 1'b1;
          o_ctrl.result_src = 1'b1;
          o_ctrl.alu_ctrl   = ALU_ADD;
          o_ctrl.imm_op     = w_imm_i;
        end
      end
      STORE: begin
        if (w_f3 == F3_W) begin
          o_illegal        = 1'b0;
          o_ctrl.mem_write = 1'b1;
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.alu_ctrl  = ALU_ADD;
          o_ctrl.imm_op    = w_imm_s;
        end
      end
      BRANCH: begin
        if (w_f3 == F3_BEQ || w_f3 == F3_BNE) begin
          o_illegal        = 1'b0;
          o_ctrl.is_branch = 1'b1;
          o_ctrl.branch_ne = (w_f3 == F3_BNE);
          o_ctrl.alu_ctrl  = ALU_SUB;
          o_ctrl.imm_op    = w_imm_b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/red_fetch_ctrl.sv
// Instruction-side front end: holds PC and IR, fetches over req/valid, drives decoded controls.
// Latency: 2 cycles per instruction (FETCH + EXEC) plus one cycle per fetch wait.
// Backpressure: stays in FETCH with pc stable while imem_valid is low; imem_valid is ignored elsewhere.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   imem_req/imem_addr  - fetch request and address (= pc)
//   imem_rdata/valid    - instruction word and its valid strobe
//   Zero                - ALU zero flag, sampled in EXEC for branches
//   ImmOp..ResultSrc    - datapath control bundle, non-zero only in EXEC
//   pc, halted          - current PC and sticky halt indication
module red_fetch_ctrl
  import red_pkg::*;
#(
  parameter int               DATA_WIDTH    = 32,
  parameter int               ADDRESS_WIDTH = 5,
  parameter int               ALUctrl_WIDTH = 3,
  parameter logic [31:0]      RESET_PC      = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [DATA_WIDTH-1:0]    imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     imem_valid,
  input  logic                     Zero,
  output logic [DATA_WIDTH-1:0]    ImmOp,
  output logic                     RegWrite,
  output logic [ALUctrl_WIDTH-1:0] ALUctrl,
  output logic                     ALUsrc,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic                     MemWrite,
  output logic                     ResultSrc,
  output logic [DATA_WIDTH-1:0]    pc,
  output logic                     halted
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] w_pc_nxt;
  logic [DATA_WIDTH-1:0] r_ir;
  logic [DATA_WIDTH-1:0] w_ir_nxt;

  ctrl_t                 w_dec;
  logic                  w_illegal;
  logic [DATA_WIDTH-1:0] w_pc_inc;
  logic [DATA_WIDTH-1:0] w_br_tgt;
  logic                  w_taken;
  logic                  w_fault;

  red_decode u_decode (
    .i_ir      (r_ir),
    .o_ctrl    (w_dec),
    .o_illegal (w_illegal)
  );

  assign w_pc_inc = r_pc + DATA_WIDTH'(4);
  assign w_br_tgt = r_pc + w_dec.imm_op;
  assign w_taken  = w_dec.is_branch & (w_dec.branch_ne ? ~Zero : Zero);
  // A taken branch to a non-word-aligned target is treated like an illegal
  // instruction: nothing commits and the core parks in HALT.
  assign w_fault  = w_illegal | (w_taken & (w_br_tgt[1:0] != 2'b00));

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign halted    = (r_state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    imem_req    = 1'b0;
    ImmOp       = '0;
    RegWrite    = 1'b0;
    ALUctrl     = '0;
    ALUsrc      = 1'b0;
    rs1         = '0;
    rs2         = '0;
    rd          = '0;
    MemWrite    = 1'b0;
    ResultSrc   = 1'b0;

    case (r_state)
      FETCH: begin
        // Reset forces FETCH asynchronously; gating with rst_n keeps the
        // request quiet for the whole reset pulse.
        imem_req = rst_n;
        if (imem_valid) begin
          w_ir_nxt    = imem_rdata;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        ImmOp     = w_dec.imm_op;
        ALUctrl   = w_dec.alu_ctrl;
        ALUsrc    = w_dec.alu_src;
        rs1       = w_dec.rs1;
        rs2       = w_dec.rs2;
        rd        = w_dec.rd;
        ResultSrc = w_dec.result_src;
        if (w_fault) begin
          w_state_nxt = HALT;
        end else begin
          RegWrite    = w_dec.reg_write;
          MemWrite    = w_dec.mem_write;
          w_pc_nxt    = w_taken ? w_br_tgt : w_pc_inc;
          w_state_nxt = FETCH;
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt = HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_red_fetch_ctrl.sv
// Randomized self-checking bench for red_fetch_ctrl against an instruction-level model.
// Latency: n/a (testbench).
// Backpressure: fetch wait cycles injected at random.
module tb_red_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        Zero;
  logic [31:0] ImmOp;
  logic        RegWrite;
  logic [2:0]  ALUctrl;
  logic        ALUsrc;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        MemWrite;
  logic        ResultSrc;
  logic [31:0] pc;
  logic        halted;

  red_fetch_ctrl #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (5),
    .ALUctrl_WIDTH (3),
    .RESET_PC      (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .Zero       (Zero),
    .ImmOp      (ImmOp),
    .RegWrite   (RegWrite),
    .ALUctrl    (ALUctrl),
    .ALUsrc     (ALUsrc),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .MemWrite   (MemWrite),
    .ResultSrc  (ResultSrc),
    .pc         (pc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model state: where the program counter should be and
  // whether the core should have stopped.
  logic [31:0] mpc;
  logic        mhalt;

  typedef struct packed {
    logic        legal;
    logic        rw;
    logic        mw;
    logic        rsrc;
    logic        asrc;
    logic [2:0]  actrl;
    logic        chk_imm;
    logic [31:0] imm;
    logic        br;
    logic        bne;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-set view of each supported instruction.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t               e;
    logic signed [31:0] sw;
    logic [31:0]        imm_i;
    int                 b;
    e     = '0;
    sw    = w;
    imm_i = sw >>> 20;
    b     = w[31] ? -4096 : 0;
    b     = b + (w[7] ? 2048 : 0) + 32 * int'(w[30:25]) + 2 * int'(w[11:8]);
    if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin
      e.legal = 1; e.rw = 1; e.asrc = 1; e.actrl = 3'd0; e.chk_imm = 1; e.imm = imm_i;
    end else if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && (w[31:25] == 7'h00 || w[31:25] == 7'h20)) begin
      e.legal = 1; e.rw = 1; e.asrc = 0; e.actrl = (w[31:25] == 7'h20) ? 3'd1 : 3'd0;
    end else if (w[6:0] == 7'h03 && w[14:12] == 3'd2) begin
      e.legal = 1; e.rw = 1; e.asrc = 1; e.rsrc = 1; e.actrl = 3'd0; e.chk_imm = 1; e.imm = imm_i;
    end else if (w[6:0] == 7'h23 && w[14:12] == 3'd2) begin
      e.legal = 1; e.mw = 1; e.asrc = 1; e.actrl = 3'd0; e.chk_imm = 1;
      e.imm = (imm_i & ~32'h1F) | {27'd0, w[11:7]};
    end else if (w[6:0] == 7'h63 && (w[14:12] == 3'd0 || w[14:12] == 3'd1)) begin
      e.legal = 1; e.br = 1; e.bne = w[12]; e.asrc = 0; e.actrl = 3'd1; e.chk_imm = 1;
      e.imm = b;
    end
    return e;
  endfunction

  task automatic do_reset();
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    Zero       = 1'b0;
    #1;
    chk("rst_req",    imem_req, 0);
    chk("rst_pc",     pc, 32'h0);
    chk("rst_halted", halted, 0);
    chk("rst_en",     {RegWrite, MemWrite, ResultSrc, ALUsrc, ALUctrl}, 0);
    chk("rst_imm",    ImmOp, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_req",  imem_req, 1);
    chk("rel_addr", imem_addr, 32'h0);
    mpc   = 32'h0;
    mhalt = 1'b0;
  endtask

  // Present one instruction after 'waits' idle fetch cycles, then check the
  // EXEC-cycle controls and the architectural effect.
  task automatic run_instr(input logic [31:0] w, input int waits, input logic z);
    exp_t        e;
    logic        taken;
    logic        fault;
    logic [31:0] tgt;
    e = ref_decode(w);
    for (int k = 0; k < waits; k++) begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      #1;
      chk("wait_req",  imem_req, 1);
      chk("wait_addr", imem_addr, mpc);
      chk("wait_en",   {RegWrite, MemWrite, ResultSrc, ALUsrc, ImmOp}, 0);
      tick();
    end
    imem_valid = 1'b1;
    imem_rdata = w;
    #1;
    chk("fetch_req",  imem_req, 1);
    chk("fetch_addr", imem_addr, mpc);
    chk("fetch_en",   {RegWrite, MemWrite}, 0);
    tick();
    // EXEC: fetch inputs here must be ignored
    imem_valid = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    Zero       = z;
    #1;
    taken = e.br && (e.bne ? !z : z);
    tgt   = mpc + e.imm;
    fault = !e.legal || (taken && tgt[1:0] != 2'b00);
    chk("exec_req", imem_req, 0);
    chk("exec_rs1", rs1, w[19:15]);
    chk("exec_rs2", rs2, w[24:20]);
    chk("exec_rd",  rd,  w[11:7]);
    chk("exec_rw",  RegWrite, fault ? 1'b0 : e.rw);
    chk("exec_mw",  MemWrite, fault ? 1'b0 : e.mw);
    if (!fault) begin
      chk("exec_rsrc",  ResultSrc, e.rsrc);
      chk("exec_asrc",  ALUsrc, e.asrc);
      chk("exec_actrl", ALUctrl, e.actrl);
      if (e.chk_imm) chk("exec_imm", ImmOp, e.imm);
    end
    tick();
    imem_valid = 1'b0;
    if (fault) mhalt = 1'b1;
    else       mpc = taken ? tgt : mpc + 32'd4;
    #1;
    chk("post_pc",     pc, mpc);
    chk("post_halted", halted, mhalt);
    chk("post_req",    imem_req, !mhalt);
    chk("post_en",     {RegWrite, MemWrite}, 0);
  endtask

  task automatic check_halt_hold(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      imem_valid = 1'($urandom_range(0, 1));
      tick();
      chk("halt_flag", halted, 1);
      chk("halt_req",  imem_req, 0);
      chk("halt_pc",   pc, mpc);
      chk("halt_en",   {RegWrite, MemWrite}, 0);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  r_d, r_s1, r_s2;
    logic [11:0] i12;
    logic [12:0] bo;
    logic [2:0]  f3;
    int          sel;
    r_d  = 5'($urandom);
    r_s1 = 5'($urandom);
    r_s2 = 5'($urandom);
    i12  = 12'($urandom);
    sel  = $urandom_range(0, 15);
    case (sel)
      3:      return {7'h00, r_s2, r_s1, 3'd0, r_d, 7'h33};
      4:      return {7'h20, r_s2, r_s1, 3'd0, r_d, 7'h33};
      5, 6:   return {i12, r_s1, 3'd2, r_d, 7'h03};
      7, 8:   return {i12[11:5], r_s2, r_s1, 3'd2, i12[4:0], 7'h23};
      9, 10, 11: begin
        bo    = 13'($urandom);
        bo[0] = 1'b0;
        if ($urandom_range(0, 7) != 0) bo[1] = 1'b0;
        return {bo[12], bo[10:5], r_s2, r_s1, 2'b00, 1'($urandom_range(0, 1)), bo[4:1], bo[11], 7'h63};
      end
      12:     return $urandom;
      13: begin
        f3 = 3'($urandom_range(1, 7));
        return {i12, r_s1, f3, r_d, 7'h13};
      end
      default: return {i12, r_s1, 3'd0, r_d, 7'h13};
    endcase
  endfunction

  initial begin
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    Zero       = 1'b0;
    mpc        = '0;
    mhalt      = 1'b0;

    // addi a0,x0,5 with same-cycle valid
    do_reset();
    run_instr(32'h00500513, 0, 1'b0);
    chk("t1_pc", pc, 32'h4);

    // bne a0,x0,-8 at pc 0x10, not-zero then zero
    do_reset();
    repeat (4) run_instr(32'h00000013, 0, 1'b0);
    chk("t2_pc_pre", pc, 32'h10);
    run_instr(32'hFE051CE3, 0, 1'b0);
    chk("t2_taken", pc, 32'h8);
    do_reset();
    repeat (4) run_instr(32'h00000013, 0, 1'b0);
    run_instr(32'hFE051CE3, 0, 1'b1);
    chk("t2_not_taken", pc, 32'h14);

    // sw a0,4(x0)
    run_instr(32'h00A02223, 0, 1'b0);

    // three fetch wait cycles
    run_instr(32'h00500513, 3, 1'b0);

    // all-zero word is illegal
    run_instr(32'h00000000, 1, 1'b0);
    chk("t5_halted", halted, 1);
    check_halt_hold(6);

    // reset pulse in the middle of EXEC
    do_reset();
    imem_valid = 1'b1;
    imem_rdata = 32'h00500513;
    tick();
    imem_valid = 1'b0;
    #1;
    chk("t6_rw_exec", RegWrite, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rw_drop", RegWrite, 0);
    chk("t6_pc",      pc, 32'h0);
    chk("t6_req",     imem_req, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_refetch", imem_req, 1);
    mpc   = 32'h0;
    mhalt = 1'b0;
    run_instr(32'h00500513, 0, 1'b0);
    chk("t6_pc_after", pc, 32'h4);

    // random program stream
    for (int n = 0; n < 400; n++) begin
      run_instr(rand_instr(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if (mhalt) begin
        check_halt_hold(2);
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/red_fetch_ctrl.md
Name: red_fetch_ctrl

Overview:
- Instruction-side front end that drives the reduced RV32I datapath.
- Holds the PC and fetches 32-bit instructions over a req/valid handshake.
- Decodes each instruction into the datapath control bundle: ImmOp, RegWrite, ALUctrl, ALUsrc, rs1, rs2, rd, MemWrite, ResultSrc.
- Consumes the datapath's Zero flag to resolve branches. Sits between instruction memory and the datapath top.

Parameters:
- DATA_WIDTH, 32, instruction/immediate/PC width
- ADDRESS_WIDTH, 5, register specifier width
- ALUctrl_WIDTH, 3, ALU control width
- RESET_PC, 32'h0000_0000, PC value after reset

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, imem_addr valid
- imem_addr  out  DATA_WIDTH  fetch address (= pc)
- imem_rdata  in  DATA_WIDTH  instruction word
- imem_valid  in  1  imem_rdata valid this cycle
- Zero  in  1  ALU zero flag from datapath
- ImmOp  out  DATA_WIDTH  sign-extended immediate
- RegWrite  out  1  register file write enable
- ALUctrl  out  ALUctrl_WIDTH  ALU operation
- ALUsrc  out  1  1 = ALU operand 2 is ImmOp
- rs1, rs2, rd  out  ADDRESS_WIDTH each  register specifiers
- MemWrite  out  1  data memory write enable
- ResultSrc  out  1  1 = writeback from data memory
- pc  out  DATA_WIDTH  current PC
- halted  out  1  sticky halt indication

Behaviour:
Reset (async, rst_n=0):
- state=FETCH, pc=RESET_PC, instruction register ir=0, halted=0.
- All control outputs are 0.
- imem_req=0 while rst_n is low; it asserts in the first cycle after release.

FSM, states FETCH, EXEC, HALT:
- FETCH: imem_req=1, imem_addr=pc.
  - RegWrite, MemWrite, ResultSrc, ALUsrc, ImmOp, rs*, rd, ALUctrl are forced to 0.
  - imem_valid=1: latch imem_rdata into ir, go to EXEC. Same-cycle valid is allowed (combinational ROM).
  - imem_valid=0: stay in FETCH, pc stable.
- EXEC: exactly one cycle, imem_req=0. Outputs are decoded combinationally from ir.
  - Register and memory writes commit on the clk edge that ends EXEC.
  - Next pc = pc+4. For a taken branch, next pc = pc+ImmB (modulo 2^32). Then go to FETCH.
  - Illegal instruction, or taken-branch target with bits[1:0]≠0: no write enables asserted, pc unchanged, go to HALT.
- HALT: terminal until reset. halted=1, imem_req=0, all enables 0.
- imem_valid outside FETCH is ignored.
- Throughput: minimum 2 cycles per instruction, plus one cycle per fetch wait cycle.

Decode. Any other opcode/funct combination is illegal.
- addi (0010011, f3=000): RegWrite=1, ALUsrc=1, ALUctrl=ADD, ImmOp=I-imm.
- add/sub (0110011, f3=000, f7=0000000/0100000): RegWrite=1, ALUsrc=0, ALUctrl=ADD/SUB.
- lw (0000011, f3=010): RegWrite=1, ALUsrc=1, ResultSrc=1, ALUctrl=ADD, ImmOp=I-imm.
- sw (0100011, f3=010): MemWrite=1, ALUsrc=1, ALUctrl=ADD, ImmOp=S-imm.
- beq/bne (1100011, f3=000/001): ALUsrc=0, ALUctrl=SUB, ImmOp=B-imm.
  - Taken when Zero=1 (beq) or Zero=0 (bne).
  - Zero is sampled in EXEC only.

Encodings and field rules:
- ALUctrl: ADD=000, SUB=001.
- rs1/rs2/rd always come from ir fields in EXEC, including for instruction types that do not use them.
- Reset during EXEC: write enables drop asynchronously and no write commits.

Decomposition:
- Package red_pkg:
  - opcode constants OP_IMM, OP, LOAD, STORE, BRANCH
  - funct3/funct7 constants
  - ALUctrl codes ALU_ADD, ALU_SUB
  - state enum {FETCH, EXEC, HALT}
  - control-bundle struct
- Sub-module red_decode: purely combinational ir → control bundle + illegal flag + immediate generation (I/S/B).
- red_fetch_ctrl owns the FSM, pc and ir.

Test Plan:
1. Reset release, ROM returns 0x00500513 with same-cycle valid:
   - EXEC cycle shows RegWrite=1, ALUsrc=1, ImmOp=5, rd=10, rs1=0.
   - pc goes 0x0→0x4; 2 cycles total.
2. pc=0x10, ir=0xFE051CE3 (bne a0,x0,-8):
   - Zero=0 → next pc=0x08.
   - Zero=1 → next pc=0x14.
   - RegWrite=MemWrite=0 in both cases.
3. ir=0x00A02223 (sw a0,4(x0)):
   - MemWrite=1 for exactly one cycle, ImmOp=4, rs2=10, ALUsrc=1, RegWrite=0.
4. imem_valid held low for 3 cycles after imem_req:
   - imem_req stays 1, pc and imem_addr stable, all enables 0.
   - EXEC begins the cycle after valid.
5. ir=0x00000000 (illegal):
   - No enables, halted=1 from the next cycle, imem_req=0.
   - pc unchanged indefinitely; only rst_n clears it.
6. rst_n pulsed low mid-EXEC of an addi:
   - RegWrite drops immediately, no write commits.
   - pc=RESET_PC; fetch restarts the cycle after release.
